// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: response codes, write/read FSM states and the
// byte-strobe merge used by the register bank.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axilite_s_regfile.sv
// NUM_REGS x 32-bit register bank with one byte-strobed write port and an
// asynchronous-index read port; read sees the pre-write value on a write edge.
module axilite_s_regfile
    import axilite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] regs [NUM_REGS];

    // NOTE: this bank is reset on purpose -- every register must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[widx] <= apply_strb(regs[widx], wdata, wstrb);
        end
    end

    assign rdata = regs[ridx];

endmodule

// File: rtl/axilite_s.sv
// AXI4-Lite slave: independent write and read FSMs in front of a register bank,
// with byte strobes, SLVERR on out-of-range addresses and a post-write event pulse.
module axilite_s
    import axilite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 32
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              wr_evt
);

    localparam int                IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;
    logic              wr_evt_q;

    logic              aw_rdy, w_rdy, aw_hs, w_hs, ar_hs;
    logic              latch_aw, latch_w, commit;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_data;
    logic [3:0]        c_strb;
    logic              c_ok, rf_we, ar_ok;
    logic [31:0]       rf_rdata;

    // Ready decode from state only; reset forces every ready low.
    always_comb begin
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        unique case (w_state)
            W_IDLE:      begin aw_rdy = 1'b1; w_rdy = 1'b1; end
            W_HAVE_ADDR: w_rdy  = 1'b1;
            W_HAVE_DATA: aw_rdy = 1'b1;
            default:     ;
        endcase
    end

    assign s_axi_awready = aw_rdy & ~s_axi_areset;
    assign s_axi_wready  = w_rdy & ~s_axi_areset;
    assign s_axi_arready = (r_state == R_IDLE) & ~s_axi_areset;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign w_hs          = s_axi_wvalid & s_axi_wready;
    assign ar_hs         = s_axi_arvalid & s_axi_arready;

    // NOTE: every output of this block gets a default first, otherwise the untaken branches infer latches.
    always_comb begin
        w_next   = w_state;
        latch_aw = 1'b0;
        latch_w  = 1'b0;
        commit   = 1'b0;
        c_addr   = aw_addr_q;
        c_data   = w_data_q;
        c_strb   = w_strb_q;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_addr = s_axi_awaddr;
                    c_data = s_axi_wdata;
                    c_strb = s_axi_wstrb;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    latch_aw = 1'b1;
                    w_next   = W_HAVE_ADDR;
                end else if (w_hs) begin
                    latch_w = 1'b1;
                    w_next  = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = s_axi_wdata;
                    c_strb = s_axi_wstrb;
                    w_next = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_addr = s_axi_awaddr;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign c_ok  = (c_addr < ADDR_LIMIT);
    assign rf_we = commit & c_ok;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            wr_evt_q  <= 1'b0;
        end else begin
            w_state  <= w_next;
            wr_evt_q <= rf_we;
            if (latch_aw) aw_addr_q <= s_axi_awaddr;
            if (latch_w) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (commit) bresp_q <= c_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_ok = (s_axi_araddr < ADDR_LIMIT);

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rdata_q <= ar_ok ? rf_rdata : 32'h0;
                rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axilite_s_regfile #(
        .NUM_REGS(NUM_REGS),
        .IDX_W   (IDX_W)
    ) u_regfile (
        .clk  (s_axi_aclk),
        .rst  (s_axi_areset),
        .we   (rf_we),
        .widx (c_addr[IDX_W+1:2]),
        .wdata(c_data),
        .wstrb(c_strb),
        .ridx (s_axi_araddr[IDX_W+1:2]),
        .rdata(rf_rdata)
    );

    assign s_axi_bvalid = (w_state == W_RESP);
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = (r_state == R_DATA);
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign wr_evt       = wr_evt_q;

endmodule

// File: tb/tb_axilite_s.sv
// Directed bench for axilite_s: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed for a 16-register bank.
module tb_axilite_s;

    logic        clk;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, wr_evt;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int total = 0;
    int bad   = 0;
    int evt_cnt;
    int b_cnt;

    logic [31:0] rd_data;
    logic [1:0]  rd_resp, wr_resp;

    axilite_s #(.NUM_REGS(16), .ADDR_W(32)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_awaddr (awaddr),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_bresp  (bresp),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_araddr (araddr),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .wr_evt       (wr_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full write: AW and W presented together, each dropped once accepted; counts wr_evt cycles.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int   n;
        logic a_hs, w_hs, aw_done, w_done;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            @(negedge clk);
            evt_cnt += int'(wr_evt);
            n++;
            if (a_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs) begin w_done = 1'b1; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            evt_cnt += int'(wr_evt);
            n++;
        end
        if (!bvalid) begin
            check("write_timeout", 32'(bvalid), 32'd1);
            resp = 2'b11;
        end else begin
            resp = bresp;
            @(negedge clk);
            evt_cnt += int'(wr_evt);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            check("read_timeout", 32'(rvalid), 32'd1);
            d = 32'hxxxx_xxxx;
            resp = 2'b11;
        end else begin
            d = rdata;
            resp = rresp;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        evt_cnt = 0; b_cnt = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_readys", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_evt", 32'(wr_evt), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_readys", {29'd0, awready, wready, arready}, 32'd7);

        // 1: AW+W on the same edge
        @(negedge clk);
        awaddr = 32'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_bvalid", 32'(bvalid), 32'd1);
        check("t1_bresp", 32'(bresp), 32'd0);
        check("t1_evt", 32'(wr_evt), 32'd1);
        @(negedge clk);
        check("t1_bdone", {30'd0, bvalid, wr_evt}, 32'd0);
        do_read(32'h08, rd_data, rd_resp);
        check("t1_rdata", rd_data, 32'hDEADBEEF);
        check("t1_rresp", 32'(rd_resp), 32'd0);

        // 2: W three cycles ahead of AW, partial strobes
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        evt_cnt = 0; b_cnt = 0;
        @(negedge clk);
        wvalid = 1'b0;
        check("t2_have_data", {30'd0, awready, wready}, 32'd2);
        repeat (2) begin
            @(negedge clk);
            evt_cnt += int'(wr_evt);
            b_cnt   += int'(bvalid);
        end
        awaddr = 32'h04; awvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            awvalid = 1'b0;
            evt_cnt += int'(wr_evt);
            b_cnt   += int'(bvalid);
        end
        check("t2_evt_pulses", 32'(evt_cnt), 32'd1);
        check("t2_b_count", 32'(b_cnt), 32'd1);
        do_read(32'h04, rd_data, rd_resp);
        check("t2_rdata", rd_data, 32'h00220044);

        // 3: out-of-range write/read, plus top-of-range with low bits set
        evt_cnt = 0;
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, wr_resp);
        check("t3_bresp", 32'(wr_resp), 32'd2);
        check("t3_no_evt", 32'(evt_cnt), 32'd0);
        do_read(32'h00, rd_data, rd_resp);
        check("t3_reg0_same", rd_data, 32'd0);
        do_read(32'h40, rd_data, rd_resp);
        check("t3_rdata", rd_data, 32'd0);
        check("t3_rresp", 32'(rd_resp), 32'd2);
        do_write(32'h3F, 32'h0F0F0F0F, 4'hF, wr_resp);
        check("t3_top_bresp", 32'(wr_resp), 32'd0);
        do_read(32'h3C, rd_data, rd_resp);
        check("t3_top_rdata", rd_data, 32'h0F0F0F0F);

        // 4: B backpressure for 5 cycles
        awaddr = 32'h0C; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold", {29'd0, bvalid, awready, wready}, 32'd4);
            check("t4_bresp", 32'(bresp), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("t4_after_b", {29'd0, bvalid, awready, wready}, 32'd3);

        // Write commit and read of the same register on one edge returns the old value
        awaddr = 32'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 32'h0C; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_edge_old", rdata, 32'h12345678);
        check("same_edge_b", 32'(bvalid), 32'd1);
        rready = 1'b1;
        @(negedge clk);
        do_read(32'h0C, rd_data, rd_resp);
        check("same_edge_new", rd_data, 32'hCAFEF00D);

        // 5: R backpressure with a concurrent write to another register
        do_write(32'h08, 32'hA5A5A5A5, 4'hF, wr_resp);
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        awaddr = 32'h10; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_rdata", rdata, 32'hA5A5A5A5);
            check("t5_rv_resp", {29'd0, rvalid, rresp}, 32'd4);
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0;
            if (i == 0) check("t5_bvalid", {30'd0, bvalid, bresp[1]}, 32'd2);
        end
        rready = 1'b1;
        @(negedge clk);
        check("t5_rdone", 32'(rvalid), 32'd0);
        do_read(32'h10, rd_data, rd_resp);
        check("t5_other_reg", rd_data, 32'h0BADF00D);

        // 6: reset while in W_HAVE_ADDR and R_DATA
        awaddr = 32'h14; awvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        check("t6_have_addr", {30'd0, awready, wready}, 32'd1);
        check("t6_rvalid", 32'(rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_readys", {29'd0, awready, wready, arready}, 32'd0);
        @(negedge clk);
        check("t6_rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        b_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            b_cnt += int'(bvalid);
        end
        check("t6_addr_dropped", 32'(b_cnt), 32'd0);
        do_read(32'h08, rd_data, rd_resp);
        check("t6_reg2_zero", rd_data, 32'd0);
        do_read(32'h0C, rd_data, rd_resp);
        check("t6_reg3_zero", rd_data, 32'd0);
        do_read(32'h10, rd_data, rd_resp);
        check("t6_reg4_zero", rd_data, 32'd0);
        do_read(32'h3C, rd_data, rd_resp);
        check("t6_reg15_zero", rd_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
